// File: rtl/shiftr_rotr_seq4.sv
// Sequential 4-bit shift-right / rotate-right engine: one bit position per clock,
// result held under a valid/ack handshake until consumed.
module shiftr_rotr_seq4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] ctrl,
    input  logic [3:0] in,
    input  logic       out_ack,
    output logic       busy,
    output logic       out_valid,
    output logic [3:0] out
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t     state;
    logic [3:0] shreg;
    logic [2:0] cnt;
    logic       rot;

    logic [2:0] dec_n;
    logic       dec_rot;

    // Opcode 100 is a full 4-position logical shift, which always yields zero.
    always_comb begin
        dec_n   = 3'd0;
        dec_rot = 1'b0;
        case (ctrl)
            3'b000: begin dec_n = 3'd0; dec_rot = 1'b0; end
            3'b001: begin dec_n = 3'd1; dec_rot = 1'b0; end
            3'b010: begin dec_n = 3'd2; dec_rot = 1'b0; end
            3'b011: begin dec_n = 3'd3; dec_rot = 1'b0; end
            3'b100: begin dec_n = 3'd4; dec_rot = 1'b0; end
            3'b101: begin dec_n = 3'd1; dec_rot = 1'b1; end
            3'b110: begin dec_n = 3'd2; dec_rot = 1'b1; end
            3'b111: begin dec_n = 3'd3; dec_rot = 1'b1; end
            default: begin dec_n = 3'd0; dec_rot = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            rot       <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= in;
                        cnt   <= dec_n;
                        rot   <= dec_rot;
                        busy  <= 1'b1;
                        if (dec_n == 3'd0) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= {(rot ? shreg[0] : 1'b0), shreg[3:1]};
                    cnt   <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out = shreg;

endmodule

// File: tb/tb_shiftr_rotr_seq4.sv
// Scoreboard bench for shiftr_rotr_seq4: the driver queues expected results,
// a negedge monitor pops them when out_valid rises and checks value and latency.
module tb_shiftr_rotr_seq4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] ctrl;
    logic [3:0] in;
    logic       out_ack;
    logic       busy;
    logic       out_valid;
    logic [3:0] out;

    shiftr_rotr_seq4 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ctrl     (ctrl),
        .in       (in),
        .out_ack  (out_ack),
        .busy     (busy),
        .out_valid(out_valid),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] res;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: first valid cycle pops the scoreboard; later valid cycles check stability.
    logic       prev_valid = 1'b0;
    logic [3:0] held;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    held = x.res;
                    check("result", int'(out), int'(x.res));
                    check("latency", cyc - x.acc + 1, x.lat);
                    check("busy_in_hold", int'(busy), 1);
                end
            end else if (out_valid === 1'b1) begin
                check("hold_stable", int'(out), int'(held));
            end
            prev_valid = out_valid;
        end
    end

    function automatic logic [3:0] model(input logic [2:0] c, input logic [3:0] d);
        logic [7:0] dd;
        int         n;
        n  = (c == 3'b100) ? 4 : int'(c[1:0]);
        dd = {d, d} >> n;
        if (c[2] && c[1:0] != 2'b00) return dd[3:0];
        return d >> n;
    endfunction

    function automatic int model_lat(input logic [2:0] c);
        return ((c == 3'b100) ? 4 : int'(c[1:0])) + 1;
    endfunction

    task automatic do_op(input logic [2:0] c, input logic [3:0] d, input logic [3:0] e,
                         input int lat, input int hold, input bit toggle);
        exp_t x;
        int   w;
        x.res = e;
        x.lat = lat;
        x.acc = cyc + 1;
        sb.push_back(x);
        ctrl  = c;
        in    = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin
            if (toggle) begin
                ctrl = ~ctrl;
                in   = in + 4'd5;
            end
            @(negedge clk);
            w++;
        end
        if (out_valid !== 1'b1) begin
            check("valid_timeout", 0, 1);
            sb.delete();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            ctrl  = ~c;
            in    = ~d;
            @(negedge clk);
        end
        start   = 1'b0;
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("ack_valid_low", int'(out_valid), 0);
        check("ack_busy_low", int'(busy), 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b1;
        ctrl    = 3'b111;
        in      = 4'b1011;
        out_ack = 1'b0;

        // Reset dominates a pending start.
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_out", int'(out), 0);
        @(negedge clk);
        check("rst_out2", int'(out), 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_valid", int'(out_valid), 0);
        check("post_rst_out", int'(out), 0);

        // Directed vectors, back-to-back starts right after each ack.
        do_op(3'b000, 4'b1011, 4'b1011, 1, 0, 0);
        do_op(3'b001, 4'b1011, 4'b0101, 2, 0, 0);
        do_op(3'b010, 4'b1011, 4'b0010, 3, 0, 0);
        do_op(3'b011, 4'b1011, 4'b0001, 4, 0, 0);
        do_op(3'b100, 4'b1011, 4'b0000, 5, 0, 0);
        do_op(3'b101, 4'b1011, 4'b1101, 2, 0, 0);
        do_op(3'b110, 4'b1011, 4'b1110, 3, 0, 0);
        do_op(3'b111, 4'b1011, 4'b0111, 4, 0, 0);

        // Long hold with ignored start pulses.
        do_op(3'b101, 4'b0110, 4'b0011, 2, 10, 0);
        // Inputs toggling after acceptance.
        do_op(3'b110, 4'b0110, 4'b1001, 3, 0, 1);

        // Abort during the second shift cycle.
        ctrl  = 3'b011;
        in    = 4'b1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out", int'(out), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(out_valid), 0);
        repeat (6) @(negedge clk);
        check("abort_idle_busy", int'(busy), 0);
        do_op(3'b010, 4'b1100, 4'b0011, 3, 0, 0);

        // Full sweep against the reference model.
        for (int c = 0; c < 8; c++) begin
            for (int d = 0; d < 16; d++) begin
                do_op(3'(c), 4'(d), model(3'(c), 4'(d)), model_lat(3'(c)), 0, 0);
            end
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
